iic_share_arb: RTL and testbench

- Two-client arbiter that time-shares the single I2C/SCCB byte master between configuration controllers, e.g. the MS7210 HDMI-TX init sequencer and the OV5640 camera register loader.
- Each client keeps its native command interface: trig pulse, w_r, 16-bit register address, write data, busy, read data and byte_over.
- The block queues one transaction per client, grants the master round-robin, and routes status back only to the granted client.
- Sits between the client controllers and the I2C master on the config clock domain.

---
 rtl/iic_share_arb.sv | 182 ++++++++++++++++++
 tb/tb_iic_share_arb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_share_arb.sv
// iic_share_arb: time-shares one I2C/SCCB byte master between two configuration
// clients, holding one queued transaction per client and granting round-robin.
module iic_share_arb #(
    parameter int unsigned TRIG_TIMEOUT = 1023,
    parameter int unsigned TO_W         = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        c0_trig,
    input  logic        c0_w_r,
    input  logic [7:0]  c0_dev,
    input  logic [15:0] c0_addr,
    input  logic [7:0]  c0_wdata,
    output logic        c0_busy,
    output logic [7:0]  c0_rdata,
    output logic        c0_byte_over,
    input  logic        c1_trig,
    input  logic        c1_w_r,
    input  logic [7:0]  c1_dev,
    input  logic [15:0] c1_addr,
    input  logic [7:0]  c1_wdata,
    output logic        c1_busy,
    output logic [7:0]  c1_rdata,
    output logic        c1_byte_over,
    output logic        m_trig,
    output logic        m_w_r,
    output logic [7:0]  m_dev,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic        m_busy,
    input  logic [7:0]  m_rdata,
    input  logic        m_byte_over,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TRIG_TIMEOUT);

    state_t          state_q;
    logic [1:0]      pend_q;
    logic [1:0]      grant_q;
    logic            last_q;
    logic            own_q;
    logic            sel_d;
    logic            abort_q;
    logic            timeout_q;
    logic [TO_W-1:0] cnt_q;

    logic            m_trig_q;
    logic            m_w_r_q;
    logic [7:0]      m_dev_q;
    logic [15:0]     m_addr_q;
    logic [7:0]      m_wdata_q;

    logic [1:0]      trig_in;
    logic [1:0]      w_r_in;
    logic [7:0]      dev_in   [2];
    logic [15:0]     addr_in  [2];
    logic [7:0]      wdata_in [2];

    logic [1:0]      slot_w_r_q;
    logic [7:0]      slot_dev_q   [2];
    logic [15:0]     slot_addr_q  [2];
    logic [7:0]      slot_wdata_q [2];
    logic [7:0]      rdata_q      [2];

    assign trig_in     = {c1_trig, c0_trig};
    assign w_r_in      = {c1_w_r, c0_w_r};
    assign dev_in[0]   = c0_dev;
    assign dev_in[1]   = c1_dev;
    assign addr_in[0]  = c0_addr;
    assign addr_in[1]  = c1_addr;
    assign wdata_in[0] = c0_wdata;
    assign wdata_in[1] = c1_wdata;

    // A lone request wins outright; on a tie the client not served last wins.
    always_comb begin
        sel_d = pend_q[1];
        if (pend_q == 2'b11) begin
            sel_d = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            grant_q    <= '0;
            last_q     <= 1'b1;
            own_q      <= 1'b0;
            abort_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            m_trig_q   <= 1'b0;
            m_w_r_q    <= 1'b0;
            m_dev_q    <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            slot_w_r_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                slot_dev_q[i[0]]   <= '0;
                slot_addr_q[i[0]]  <= '0;
                slot_wdata_q[i[0]] <= '0;
                rdata_q[i[0]]      <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (trig_in[i[0]] && !pend_q[i[0]]) begin
                    pend_q[i[0]]       <= 1'b1;
                    slot_w_r_q[i[0]]   <= w_r_in[i[0]];
                    slot_dev_q[i[0]]   <= dev_in[i[0]];
                    slot_addr_q[i[0]]  <= addr_in[i[0]];
                    slot_wdata_q[i[0]] <= wdata_in[i[0]];
                end
            end
            m_trig_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_q != 2'b00) begin
                        own_q     <= sel_d;
                        grant_q   <= sel_d ? 2'b10 : 2'b01;
                        m_w_r_q   <= slot_w_r_q[sel_d];
                        m_dev_q   <= slot_dev_q[sel_d];
                        m_addr_q  <= slot_addr_q[sel_d];
                        m_wdata_q <= slot_wdata_q[sel_d];
                        m_trig_q  <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    abort_q <= 1'b0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (m_busy) begin
                        state_q <= RUN;
                    end else if (cnt_q == TO_LIMIT) begin
                        timeout_q <= 1'b1;
                        abort_q   <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!m_busy) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // An aborted transaction leaves the client's last read byte intact.
                    if (!abort_q) begin
                        rdata_q[own_q] <= m_rdata;
                    end
                    pend_q[own_q] <= 1'b0;
                    last_q        <= own_q;
                    grant_q       <= '0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c0_busy      = pend_q[0];
    assign c1_busy      = pend_q[1];
    assign c0_rdata     = rdata_q[0];
    assign c1_rdata     = rdata_q[1];
    assign c0_byte_over = m_byte_over & grant_q[0];
    assign c1_byte_over = m_byte_over & grant_q[1];
    assign m_trig       = m_trig_q;
    assign m_w_r        = m_w_r_q;
    assign m_dev        = m_dev_q;
    assign m_addr       = m_addr_q;
    assign m_wdata      = m_wdata_q;
    assign grant        = grant_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_iic_share_arb.sv
// Bench for iic_share_arb: directed table, corner sequences and a randomized
// run against a transaction-level arbitration model, with a simple I2C master model.
module tb_iic_share_arb;

    localparam int TT = 1023;

    logic        clk, rstn;
    logic        c0_trig, c0_w_r, c0_busy, c0_byte_over;
    logic [7:0]  c0_dev, c0_wdata, c0_rdata;
    logic [15:0] c0_addr;
    logic        c1_trig, c1_w_r, c1_busy, c1_byte_over;
    logic [7:0]  c1_dev, c1_wdata, c1_rdata;
    logic [15:0] c1_addr;
    logic        m_trig, m_w_r, m_busy, m_byte_over;
    logic [7:0]  m_dev, m_wdata, m_rdata;
    logic [15:0] m_addr;
    logic [1:0]  grant;
    logic        timeout_err;

    iic_share_arb #(.TRIG_TIMEOUT(TT), .TO_W(10)) dut (
        .clk(clk), .rstn(rstn),
        .c0_trig(c0_trig), .c0_w_r(c0_w_r), .c0_dev(c0_dev), .c0_addr(c0_addr),
        .c0_wdata(c0_wdata), .c0_busy(c0_busy), .c0_rdata(c0_rdata), .c0_byte_over(c0_byte_over),
        .c1_trig(c1_trig), .c1_w_r(c1_w_r), .c1_dev(c1_dev), .c1_addr(c1_addr),
        .c1_wdata(c1_wdata), .c1_busy(c1_busy), .c1_rdata(c1_rdata), .c1_byte_over(c1_byte_over),
        .m_trig(m_trig), .m_w_r(m_w_r), .m_dev(m_dev), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_rdata(m_rdata), .m_byte_over(m_byte_over),
        .grant(grant), .timeout_err(timeout_err)
    );

    int   n_chk = 0;
    int   n_err = 0;
    bit   mm_respond = 1'b1;
    int   mm_len = 4;
    logic [7:0] rd_hist [2];

    typedef struct {
        int          c;
        logic        w;
        logic [7:0]  dev;
        logic [15:0] addr;
        logic [7:0]  wd;
        int          len;
        logic [7:0]  exp_rd;
    } vec_t;
    vec_t vt [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    // Master returns a byte derived from the register address it was handed.
    function automatic logic [7:0] rd_of(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5D;
    endfunction

    // Master model: busy rises 3 cycles after m_trig and lasts blen cycles.
    initial begin : master
        int dly, left, blen;
        dly = 0; left = 0; blen = 1;
        m_busy = 1'b0; m_rdata = '0; m_byte_over = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rstn) begin
                dly = 0; left = 0;
            end else begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) left = blen;
                end
                if (m_trig && mm_respond) begin
                    dly = 3;
                    blen = (mm_len > 0) ? mm_len : int'($urandom_range(8, 1));
                    m_rdata = rd_of(m_addr);
                end
            end
            m_busy = (left > 0);
            m_byte_over = (left > 0) && (left % 4 == 2);
            if (left > 0) left--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input int c);
        return (c != 0) ? c1_busy : c0_busy;
    endfunction

    function automatic logic bo_of(input int c);
        return (c != 0) ? c1_byte_over : c0_byte_over;
    endfunction

    function automatic logic [7:0] rdata_of(input int c);
        return (c != 0) ? c1_rdata : c0_rdata;
    endfunction

    task automatic idle_in();
        c0_trig = 1'b0;
        c1_trig = 1'b0;
    endtask

    task automatic req(input int c, input logic w, input logic [7:0] d, input logic [15:0] a,
                       input logic [7:0] wd);
        if (c == 0) begin
            c0_trig = 1'b1; c0_w_r = w; c0_dev = d; c0_addr = a; c0_wdata = wd;
        end else begin
            c1_trig = 1'b1; c1_w_r = w; c1_dev = d; c1_addr = a; c1_wdata = wd;
        end
    endtask

    task automatic wait_mtrig(input string name, input int limit, output int waited);
        waited = 0;
        while (m_trig !== 1'b1 && waited < limit) begin
            tick();
            waited++;
        end
        if (m_trig !== 1'b1) begin
            n_chk++; n_err++;
            $display("FAIL %s: m_trig got 0 expected pulse within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_mbusy(input string name);
        int n;
        n = 0;
        while (m_busy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_mbusy"}, m_busy, 1'b1);
    endtask

    task automatic check_fields(input string name, input int c, input logic w, input logic [7:0] d,
                                input logic [15:0] a, input logic [7:0] wd);
        chk({name, "_grant"}, grant, (c != 0) ? 2'b10 : 2'b01);
        chk({name, "_w_r"}, m_w_r, w);
        chk({name, "_dev"}, m_dev, d);
        chk({name, "_addr"}, m_addr, a);
        chk({name, "_wdata"}, m_wdata, wd);
    endtask

    // Waits for the owner's busy to drop; checks busy-fall latency and byte_over routing.
    task automatic finish_txn(input string name, input int c, input logic [7:0] exp_rd);
        int n, last_mb;
        n = 0; last_mb = -100;
        while (busy_of(c) === 1'b1 && n < 3000) begin
            if (m_busy) last_mb = n;
            if (m_byte_over) begin
                chk({name, "_bo_own"}, bo_of(c), 1'b1);
                chk({name, "_bo_other"}, bo_of(1 - c), 1'b0);
            end
            tick();
            n++;
        end
        chk({name, "_busy_fall"}, busy_of(c), 1'b0);
        chk({name, "_fall_lat"}, n - last_mb - 1, 2);
        chk({name, "_rdata"}, rdata_of(c), exp_rd);
        chk({name, "_rdata_other"}, rdata_of(1 - c), rd_hist[1 - c]);
        chk({name, "_grant_clr"}, grant, 2'b00);
        rd_hist[c] = exp_rd;
    endtask

    task automatic serve(input string name, input int c, input logic w, input logic [7:0] d,
                         input logic [15:0] a, input logic [7:0] wd, input logic [7:0] exp_rd,
                         input int exp_wait);
        int waited;
        wait_mtrig(name, 3000, waited);
        if (exp_wait >= 0) chk({name, "_trig_lat"}, waited, exp_wait);
        check_fields(name, c, w, d, a, wd);
        tick();
        chk({name, "_trig_1cyc"}, m_trig, 1'b0);
        finish_txn(name, c, exp_rd);
    endtask

    task automatic count_trigs(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (m_trig) cnt++;
            tick();
        end
    endtask

    // Randomized run: arbitration rules modelled per cycle at the transaction level.
    task automatic random_run(input int cycles);
        logic [1:0]  mp, np, mgrant;
        logic        mlast, mown, mfree, mdue, nd, msaw, mdone, t0, t1;
        logic        sw [2];
        logic [7:0]  sd [2], swd [2], mrd [2];
        logic [15:0] sa [2];
        mp = '0; mgrant = '0; mlast = 1'b1; mown = 1'b0; mfree = 1'b1; mdue = 1'b0;
        msaw = 1'b0; mdone = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sw[i] = 1'b0; sd[i] = '0; swd[i] = '0; sa[i] = '0; mrd[i] = '0;
        end
        for (int c = 0; c < cycles; c++) begin
            chk("rnd_mtrig", m_trig, mdue);
            if (mdue) check_fields("rnd", int'(mown), sw[mown], sd[mown], sa[mown], swd[mown]);
            chk("rnd_grant", grant, mgrant);
            chk("rnd_busy0", c0_busy, mp[0]);
            chk("rnd_busy1", c1_busy, mp[1]);
            chk("rnd_rdata0", c0_rdata, mrd[0]);
            chk("rnd_rdata1", c1_rdata, mrd[1]);
            chk("rnd_bo0", c0_byte_over, m_byte_over & mgrant[0]);
            chk("rnd_bo1", c1_byte_over, m_byte_over & mgrant[1]);
            t0 = ($urandom_range(4, 0) == 0);
            t1 = ($urandom_range(4, 0) == 0);
            c0_trig = t0; c0_w_r = 1'($urandom); c0_dev = 8'($urandom);
            c0_addr = 16'($urandom); c0_wdata = 8'($urandom);
            c1_trig = t1; c1_w_r = 1'($urandom); c1_dev = 8'($urandom);
            c1_addr = 16'($urandom); c1_wdata = 8'($urandom);
            np = mp; nd = 1'b0;
            if (mfree) begin
                if (mp != 2'b00) begin
                    mown = (mp == 2'b11) ? ~mlast : mp[1];
                    mfree = 1'b0; nd = 1'b1; msaw = 1'b0; mdone = 1'b0;
                    mgrant = mown ? 2'b10 : 2'b01;
                end
            end else if (mdone) begin
                np[mown] = 1'b0;
                mrd[mown] = rd_of(sa[mown]);
                mlast = mown; mgrant = '0; mfree = 1'b1; mdone = 1'b0;
            end else begin
                if (msaw && !m_busy) mdone = 1'b1;
                if (m_busy) msaw = 1'b1;
            end
            if (t0 && !mp[0]) begin
                np[0] = 1'b1; sw[0] = c0_w_r; sd[0] = c0_dev; sa[0] = c0_addr; swd[0] = c0_wdata;
            end
            if (t1 && !mp[1]) begin
                np[1] = 1'b1; sw[1] = c1_w_r; sd[1] = c1_dev; sa[1] = c1_addr; swd[1] = c1_wdata;
            end
            mp = np;
            mdue = nd;
            tick();
        end
        idle_in();
    endtask

    initial begin
        int waited, cnt, n;
        rstn = 1'b0;
        c0_trig = 0; c0_w_r = 0; c0_dev = '0; c0_addr = '0; c0_wdata = '0;
        c1_trig = 0; c1_w_r = 0; c1_dev = '0; c1_addr = '0; c1_wdata = '0;
        rd_hist[0] = '0; rd_hist[1] = '0;

        vt[0] = '{c: 0, w: 1'b1, dev: 8'hB2, addr: 16'h0003, wd: 8'h5A, len: 40, exp_rd: 8'h5E};
        vt[1] = '{c: 1, w: 1'b0, dev: 8'h78, addr: 16'h0502, wd: 8'h00, len: 5,  exp_rd: 8'h5A};
        vt[2] = '{c: 1, w: 1'b1, dev: 8'h78, addr: 16'h3008, wd: 8'h82, len: 2,  exp_rd: 8'h65};
        vt[3] = '{c: 0, w: 1'b0, dev: 8'hB2, addr: 16'hFFFF, wd: 8'h00, len: 1,  exp_rd: 8'h5D};
        vt[4] = '{c: 0, w: 1'b1, dev: 8'h00, addr: 16'h0000, wd: 8'hFF, len: 3,  exp_rd: 8'h5D};

        repeat (3) tick();
        chk("rst_busy0", c0_busy, 1'b0);
        chk("rst_busy1", c1_busy, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_mtrig", m_trig, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_rdata", {c1_rdata, c0_rdata}, 16'h0000);
        chk("rst_mfields", {m_w_r, m_dev, m_addr, m_wdata}, 33'h0);
        rstn = 1'b1;
        tick();

        // Simultaneous requests right after reset: client 0 first, then 1, twice.
        mm_len = 4;
        req(0, 1'b1, 8'h10, 16'h0100, 8'h11);
        req(1, 1'b0, 8'h20, 16'h0200, 8'h22);
        tick(); idle_in();
        serve("tie1_c0", 0, 1'b1, 8'h10, 16'h0100, 8'h11, rd_of(16'h0100), 1);
        serve("tie1_c1", 1, 1'b0, 8'h20, 16'h0200, 8'h22, rd_of(16'h0200), 1);
        req(0, 1'b0, 8'h12, 16'h0A0B, 8'h33);
        req(1, 1'b1, 8'h24, 16'h0C0D, 8'h44);
        tick(); idle_in();
        serve("tie2_c0", 0, 1'b0, 8'h12, 16'h0A0B, 8'h33, rd_of(16'h0A0B), 1);
        serve("tie2_c1", 1, 1'b1, 8'h24, 16'h0C0D, 8'h44, rd_of(16'h0C0D), 1);

        for (int k = 0; k < 5; k++) begin
            mm_len = vt[k].len;
            req(vt[k].c, vt[k].w, vt[k].dev, vt[k].addr, vt[k].wd);
            tick(); idle_in();
            chk("vec_busy_own", busy_of(vt[k].c), 1'b1);
            chk("vec_busy_other", busy_of(1 - vt[k].c), 1'b0);
            chk("vec_no_early_trig", m_trig, 1'b0);
            serve($sformatf("vec%0d", k), vt[k].c, vt[k].w, vt[k].dev, vt[k].addr, vt[k].wd,
                  vt[k].exp_rd, 1);
        end

        // Contention during RUN; repeat triggers on a pending client are ignored.
        mm_len = 10;
        req(0, 1'b1, 8'h30, 16'h1111, 8'h01);
        tick(); idle_in();
        wait_mtrig("b2b_c0", 10, waited);
        check_fields("b2b_c0", 0, 1'b1, 8'h30, 16'h1111, 8'h01);
        wait_mbusy("b2b_c0");
        req(1, 1'b0, 8'h40, 16'h2222, 8'h00);
        tick(); idle_in();
        req(0, 1'b1, 8'h30, 16'h9999, 8'h99);
        tick(); idle_in();
        finish_txn("b2b_c0", 0, rd_of(16'h1111));
        serve("b2b_c1", 1, 1'b0, 8'h40, 16'h2222, 8'h00, rd_of(16'h2222), 1);
        count_trigs(10, cnt);
        chk("b2b_no_retrig", cnt, 0);
        req(1, 1'b1, 8'h41, 16'h3333, 8'h03);
        tick(); idle_in();
        wait_mtrig("b2b2_c1", 10, waited);
        wait_mbusy("b2b2_c1");
        req(0, 1'b0, 8'h31, 16'h4444, 8'h04);
        tick(); idle_in();
        req(0, 1'b1, 8'h3F, 16'h5555, 8'h05);
        tick(); idle_in();
        finish_txn("b2b2_c1", 1, rd_of(16'h3333));
        serve("b2b2_c0", 0, 1'b0, 8'h31, 16'h4444, 8'h04, rd_of(16'h4444), 1);

        // Master never answers: sticky timeout, rdata kept, next request still works.
        mm_respond = 1'b0;
        req(0, 1'b0, 8'h50, 16'h6666, 8'h00);
        tick(); idle_in();
        n = 1;
        while (timeout_err !== 1'b1 && n < TT + 50) begin
            tick();
            n++;
        end
        chk("to_flag", timeout_err, 1'b1);
        chk("to_window", (n >= TT) && (n <= TT + 8), 1'b1);
        n = 0;
        while (c0_busy === 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk("to_busy_fall", c0_busy, 1'b0);
        chk("to_grant", grant, 2'b00);
        chk("to_rdata_kept", c0_rdata, rd_hist[0]);
        mm_respond = 1'b1;
        mm_len = 3;
        req(1, 1'b0, 8'h60, 16'h7777, 8'h00);
        tick(); idle_in();
        serve("to_next", 1, 1'b0, 8'h60, 16'h7777, 8'h00, rd_of(16'h7777), 1);
        chk("to_sticky", timeout_err, 1'b1);

        // One-cycle reset in the middle of a transaction.
        mm_len = 20;
        req(1, 1'b1, 8'h70, 16'h8888, 8'h08);
        tick(); idle_in();
        wait_mtrig("rr", 10, waited);
        wait_mbusy("rr");
        tick();
        rstn = 1'b0;
        tick();
        chk("rr_busy", {c1_busy, c0_busy}, 2'b00);
        chk("rr_grant", grant, 2'b00);
        chk("rr_mtrig", m_trig, 1'b0);
        chk("rr_timeout", timeout_err, 1'b0);
        chk("rr_rdata", {c1_rdata, c0_rdata}, 16'h0000);
        rstn = 1'b1;
        count_trigs(30, cnt);
        chk("rr_no_trig", cnt, 0);
        chk("rr_busy_after", {c1_busy, c0_busy}, 2'b00);

        mm_len = 0;
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        random_run(3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
